// File: rtl/reg_cmd_bridge_pkg.sv
// rtl/reg_cmd_bridge_pkg.sv - shared types and command-byte layout for the register command bridge
package reg_cmd_bridge_pkg;

    localparam int ADDR_W       = 6;
    localparam int LEN_W        = 16;
    localparam int CMD_VALID    = 7;
    localparam int CMD_WRITE    = 6;
    localparam int CMD_ADDR_MSB = 5;
    localparam int CMD_ADDR_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_WDATA,
        ST_RDATA
    } state_e;

    function automatic logic [ADDR_W-1:0] cmd_addr(input logic [7:0] b);
        return b[CMD_ADDR_MSB:CMD_ADDR_LSB];
    endfunction

endpackage

// File: rtl/reg_cmd_bridge_cmdfifo_strobe.sv
// rtl/reg_cmd_bridge_cmdfifo_strobe.sv - paces command FIFO rd/wr strobes against rxf/txe
module reg_cmd_bridge_cmdfifo_strobe (
    input  logic clk,
    input  logic reset_i,
    input  logic rxf,
    input  logic txe,
    input  logic rx_req,
    input  logic tx_req,
    output logic rd,
    output logic wr
);

    // Each strobe self-clears, so rd/wr are single-cycle and never back-to-back.
    always_ff @(posedge clk) begin
        if (!reset_i) begin
            rd <= 1'b0;
            wr <= 1'b0;
        end else begin
            rd <= rx_req & rxf & ~rd;
            wr <= tx_req & ~txe & ~wr;
        end
    end

endmodule

// File: rtl/reg_cmd_bridge.sv
// rtl/reg_cmd_bridge.sv - byte-command to register-bus bridge; REGBRIDGE_DEFAULT_LEN_EN maps zero length to reg_hyplen
module reg_cmd_bridge
    import reg_cmd_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              reset_i,
    input  logic              cmdfifo_rxf,
    input  logic              cmdfifo_txe,
    input  logic [7:0]        cmdfifo_din,
    output logic              cmdfifo_rd,
    output logic              cmdfifo_wr,
    output logic [7:0]        cmdfifo_dout,
    output logic              cmdfifo_isout,
    output logic              reg_clk,
    output logic [ADDR_W-1:0] reg_address,
    output logic [LEN_W-1:0]  reg_bytecnt,
    output logic [7:0]        reg_datao,
    input  logic [7:0]        reg_datai,
    output logic [LEN_W-1:0]  reg_size,
    output logic              reg_read,
    output logic              reg_write,
    output logic              reg_addrvalid,
    output logic              reg_stream,
    output logic [ADDR_W-1:0] reg_hypaddress,
    input  logic [LEN_W-1:0]  reg_hyplen
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] hyp_q, hyp_d;
    logic              is_wr_q, is_wr_d;
    logic [LEN_W-1:0]  size_q, size_d;
    logic [LEN_W-1:0]  bytecnt_q, bytecnt_d;
    logic [7:0]        datao_q, datao_d;
    logic [7:0]        dout_q, dout_d;
    logic [1:0]        phase_q, phase_d;
    logic              write_q, write_d;
    logic              read_q, read_d;
    logic              tx_pend_q, tx_pend_d;
    logic              rx_req;
    logic              rx_valid;
    logic              tx_done;
    logic              last;
    logic [LEN_W-1:0]  len_rx;

    reg_cmd_bridge_cmdfifo_strobe u_strobe (
        .clk     (clk),
        .reset_i (reset_i),
        .rxf     (cmdfifo_rxf),
        .txe     (cmdfifo_txe),
        .rx_req  (rx_req),
        .tx_req  (tx_pend_q),
        .rd      (rx_valid),
        .wr      (tx_done)
    );

`ifndef REGBRIDGE_DEFAULT_LEN_EN
    logic unused_hyplen;
    assign unused_hyplen = ^reg_hyplen;
`endif

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            hyp_q     <= '0;
            is_wr_q   <= 1'b0;
            size_q    <= '0;
            bytecnt_q <= '0;
            datao_q   <= '0;
            dout_q    <= '0;
            phase_q   <= '0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            tx_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            hyp_q     <= hyp_d;
            is_wr_q   <= is_wr_d;
            size_q    <= size_d;
            bytecnt_q <= bytecnt_d;
            datao_q   <= datao_d;
            dout_q    <= dout_d;
            phase_q   <= phase_d;
            write_q   <= write_d;
            read_q    <= read_d;
            tx_pend_q <= tx_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        hyp_d     = hyp_q;
        is_wr_d   = is_wr_q;
        size_d    = size_q;
        bytecnt_d = bytecnt_q;
        datao_d   = datao_q;
        dout_d    = dout_q;
        phase_d   = phase_q;
        write_d   = 1'b0;
        read_d    = 1'b0;
        tx_pend_d = tx_pend_q;
        rx_req    = 1'b0;
        last      = (bytecnt_q == size_q - 16'd1);
        len_rx    = {cmdfifo_din, size_q[7:0]};
`ifdef REGBRIDGE_DEFAULT_LEN_EN
        if (len_rx == '0) begin
            len_rx = reg_hyplen;
        end
`endif
        unique case (state_q)
            ST_IDLE: begin
                rx_req = 1'b1;
                if (rx_valid && cmdfifo_din[CMD_VALID]) begin
                    addr_d  = cmd_addr(cmdfifo_din);
                    hyp_d   = cmd_addr(cmdfifo_din);
                    is_wr_d = cmdfifo_din[CMD_WRITE];
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                rx_req = 1'b1;
                if (rx_valid) begin
                    size_d  = {8'h00, cmdfifo_din};
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                rx_req = 1'b1;
                if (rx_valid) begin
                    size_d    = len_rx;
                    bytecnt_d = '0;
                    phase_d   = '0;
                    if (len_rx == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = is_wr_q ? ST_WDATA : ST_RDATA;
                    end
                end
            end
            ST_WDATA: begin
                // phase 0 fetches a payload byte, phase 1 is the reg_write cycle
                if (phase_q == 2'd0) begin
                    rx_req = 1'b1;
                    if (rx_valid) begin
                        datao_d = cmdfifo_din;
                        write_d = 1'b1;
                        phase_d = 2'd1;
                    end
                end else if (last) begin
                    state_d = ST_IDLE;
                end else begin
                    bytecnt_d = bytecnt_q + 16'd1;
                    phase_d   = 2'd0;
                end
            end
            ST_RDATA: begin
                // phases: issue read, register file responds, capture, wait for wr
                unique case (phase_q)
                    2'd0: begin
                        read_d  = 1'b1;
                        phase_d = 2'd1;
                    end
                    2'd1: phase_d = 2'd2;
                    2'd2: begin
                        dout_d    = reg_datai;
                        tx_pend_d = 1'b1;
                        phase_d   = 2'd3;
                    end
                    default: begin
                        if (tx_done) begin
                            tx_pend_d = 1'b0;
                            if (last) begin
                                state_d = ST_IDLE;
                            end else begin
                                bytecnt_d = bytecnt_q + 16'd1;
                                phase_d   = 2'd0;
                            end
                        end
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmdfifo_rd     = rx_valid;
    assign cmdfifo_wr     = tx_done;
    assign cmdfifo_dout   = dout_q;
    assign cmdfifo_isout  = (state_q == ST_RDATA);
    assign reg_clk        = clk;
    assign reg_address    = addr_q;
    assign reg_bytecnt    = bytecnt_q;
    assign reg_datao      = datao_q;
    assign reg_size       = size_q;
    assign reg_read       = read_q;
    assign reg_write      = write_q;
    assign reg_addrvalid  = (state_q != ST_IDLE);
    assign reg_stream     = ((state_q == ST_WDATA) || (state_q == ST_RDATA)) && (size_q > 16'd1);
    assign reg_hypaddress = hyp_q;

endmodule

// File: tb/tb_reg_cmd_bridge.sv
// tb/tb_reg_cmd_bridge.sv - directed self-checking bench for reg_cmd_bridge
module tb_reg_cmd_bridge;

    logic        clk;
    logic        reset_i;
    logic        cmdfifo_rxf;
    logic        cmdfifo_txe;
    logic [7:0]  cmdfifo_din;
    logic        cmdfifo_rd;
    logic        cmdfifo_wr;
    logic [7:0]  cmdfifo_dout;
    logic        cmdfifo_isout;
    logic        reg_clk;
    logic [5:0]  reg_address;
    logic [15:0] reg_bytecnt;
    logic [7:0]  reg_datao;
    logic [7:0]  reg_datai;
    logic [15:0] reg_size;
    logic        reg_read;
    logic        reg_write;
    logic        reg_addrvalid;
    logic        reg_stream;
    logic [5:0]  reg_hypaddress;
    logic [15:0] reg_hyplen;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef REGBRIDGE_DEFAULT_LEN_EN
    localparam int ZL_READS = 4;
`else
    localparam int ZL_READS = 0;
`endif

    reg_cmd_bridge dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .cmdfifo_rxf    (cmdfifo_rxf),
        .cmdfifo_txe    (cmdfifo_txe),
        .cmdfifo_din    (cmdfifo_din),
        .cmdfifo_rd     (cmdfifo_rd),
        .cmdfifo_wr     (cmdfifo_wr),
        .cmdfifo_dout   (cmdfifo_dout),
        .cmdfifo_isout  (cmdfifo_isout),
        .reg_clk        (reg_clk),
        .reg_address    (reg_address),
        .reg_bytecnt    (reg_bytecnt),
        .reg_datao      (reg_datao),
        .reg_datai      (reg_datai),
        .reg_size       (reg_size),
        .reg_read       (reg_read),
        .reg_write      (reg_write),
        .reg_addrvalid  (reg_addrvalid),
        .reg_stream     (reg_stream),
        .reg_hypaddress (reg_hypaddress),
        .reg_hyplen     (reg_hyplen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe log, written only here, sampled mid-cycle.
    int          cyc = 0;
    int          wn = 0, rn = 0, tn = 0;
    logic [5:0]  w_addr[64];
    logic [15:0] w_cnt[64];
    logic [7:0]  w_data[64];
    logic [15:0] w_size[64];
    logic        w_stream[64];
    logic        w_av[64];
    logic [5:0]  r_addr[64];
    logic [15:0] r_cnt[64];
    int          r_cyc[64];
    logic [7:0]  t_dout[64];
    logic        t_isout[64];
    int          t_cyc[64];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reg_write && wn < 64) begin
            w_addr[wn]   <= reg_address;
            w_cnt[wn]    <= reg_bytecnt;
            w_data[wn]   <= reg_datao;
            w_size[wn]   <= reg_size;
            w_stream[wn] <= reg_stream;
            w_av[wn]     <= reg_addrvalid;
            wn           <= wn + 1;
        end
        if (reg_read && rn < 64) begin
            r_addr[rn] <= reg_address;
            r_cnt[rn]  <= reg_bytecnt;
            r_cyc[rn]  <= cyc;
            rn         <= rn + 1;
        end
        if (cmdfifo_wr && tn < 64) begin
            t_dout[tn]  <= cmdfifo_dout;
            t_isout[tn] <= cmdfifo_isout;
            t_cyc[tn]   <= cyc;
            tn          <= tn + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        cmdfifo_din = b;
        cmdfifo_rxf = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            tick(1);
            if (cmdfifo_rd) begin
                tick(1);
                done = 1'b1;
            end
        end
        cmdfifo_rxf = 1'b0;
        check("rx_handshake", {31'd0, done}, 32'd1);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_strobes"}, {cmdfifo_rd, cmdfifo_wr, cmdfifo_isout, reg_read,
                                  reg_write, reg_addrvalid, reg_stream}, 32'd0);
        check({tag, "_addr"}, {reg_address, reg_hypaddress}, 32'd0);
        check({tag, "_size"}, reg_size, 32'd0);
        check({tag, "_bytecnt"}, reg_bytecnt, 32'd0);
        check({tag, "_data"}, {reg_datao, cmdfifo_dout}, 32'd0);
    endtask

    int w0, r0, t0;

    initial begin
        reset_i     = 1'b0;
        cmdfifo_rxf = 1'b0;
        cmdfifo_txe = 1'b0;
        cmdfifo_din = 8'h00;
        reg_datai   = 8'h00;
        reg_hyplen  = 16'd4;
        tick(3);
        check_idle_zero("reset");
        reset_i = 1'b1;
        tick(2);

        // single-byte write
        w0 = wn;
        send_byte(8'hC4); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAC);
        tick(4);
        check("w1_count", wn - w0, 1);
        check("w1_addr", w_addr[w0], 4);
        check("w1_cnt", w_cnt[w0], 0);
        check("w1_data", w_data[w0], 8'hAC);
        check("w1_size", w_size[w0], 1);
        check("w1_stream", w_stream[w0], 0);
        check("w1_addrvalid", w_av[w0], 1);
        check("w1_idle", reg_addrvalid, 0);
        check("w1_hyp", reg_hypaddress, 4);

        // single-byte read, transmit FIFO ready
        r0 = rn; t0 = tn;
        reg_datai = 8'h5A;
        send_byte(8'h84); send_byte(8'h01); send_byte(8'h00);
        tick(8);
        check("r1_rcount", rn - r0, 1);
        check("r1_raddr", r_addr[r0], 4);
        check("r1_rcnt", r_cnt[r0], 0);
        check("r1_tcount", tn - t0, 1);
        check("r1_dout", t_dout[t0], 8'h5A);
        check("r1_isout", t_isout[t0], 1);
        check("r1_latency", {31'd0, (t_cyc[t0] - r_cyc[r0]) >= 2}, 1);
        check("r1_idle", {cmdfifo_isout, reg_addrvalid}, 0);

        // three-byte streamed write
        w0 = wn;
        send_byte(8'hC2); send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        tick(4);
        check("w3_count", wn - w0, 3);
        for (int i = 0; i < 3; i++) begin
            check("w3_addr", w_addr[w0+i], 2);
            check("w3_cnt", w_cnt[w0+i], i);
            check("w3_data", w_data[w0+i], 8'(8'h11 * (i + 1)));
            check("w3_stream", w_stream[w0+i], 1);
            check("w3_size", w_size[w0+i], 3);
        end

        // read stalled by a full transmit FIFO
        r0 = rn; t0 = tn;
        reg_datai   = 8'h3C;
        cmdfifo_txe = 1'b1;
        send_byte(8'h85); send_byte(8'h01); send_byte(8'h00);
        tick(10);
        check("stall_tcount", tn - t0, 0);
        check("stall_rcount", rn - r0, 1);
        check("stall_isout", cmdfifo_isout, 1);
        cmdfifo_txe = 1'b0;
        tick(5);
        check("stall_tcount_after", tn - t0, 1);
        check("stall_dout", t_dout[t0], 8'h3C);
        check("stall_idle", cmdfifo_isout, 0);

        // junk byte ignored, then a normal write
        w0 = wn;
        send_byte(8'h04);
        tick(2);
        check("junk_idle", reg_addrvalid, 0);
        check("junk_hyp", reg_hypaddress, 5);
        send_byte(8'hC9); send_byte(8'h01); send_byte(8'h00); send_byte(8'h77);
        tick(4);
        check("junk_wcount", wn - w0, 1);
        check("junk_waddr", w_addr[w0], 9);
        check("junk_wdata", w_data[w0], 8'h77);

        // zero length
        r0 = rn; t0 = tn;
        send_byte(8'h86); send_byte(8'h00); send_byte(8'h00);
        tick(30);
        check("zl_rcount", rn - r0, ZL_READS);
        check("zl_tcount", tn - t0, ZL_READS);
        check("zl_idle", reg_addrvalid, 0);

        // reset between the length bytes
        w0 = wn;
        send_byte(8'hC4); send_byte(8'h01);
        check("mid_addrvalid", reg_addrvalid, 1);
        reset_i = 1'b0;
        tick(1);
        check_idle_zero("midreset");
        reset_i = 1'b1;
        tick(2);
        send_byte(8'hC3); send_byte(8'h01); send_byte(8'h00); send_byte(8'h55);
        tick(4);
        check("post_wcount", wn - w0, 1);
        check("post_waddr", w_addr[w0], 3);
        check("post_wdata", w_data[w0], 8'h55);
        check("post_idle", reg_addrvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
